// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: four-cycle IEEE-754 single-precision add/subtract responder.
// Round-to-nearest-even; denormal inputs are flushed to zero and no denormal is produced.
module fpu_addsub_seq #(
  parameter int unsigned LATENCY   = 4,
  parameter logic [31:0] CANON_NAN = 32'h7fc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  // One state per cycle of the operation plus IDLE.
  typedef enum logic [$clog2(LATENCY+1)-1:0] {
    IDLE, UNPACK, ALIGN, ADDNORM, ROUND
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sub_q, sub_d;
  logic        special_q, special_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic [3:0]  spec_flags_q, spec_flags_d;
  logic        sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [7:0]  exp_big_q, exp_big_d;
  logic [23:0] sig_big_q, sig_big_d, sig_small_q, sig_small_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [26:0] al_small_q, al_small_d;

  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, b_sign_eff, a_ge_b;
  logic [30:0] mag_a, mag_b, mag_big, mag_small;
  logic [7:0]  exp_diff;
  logic [4:0]  shamt_u;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic [3:0]  spec_flg;

  // Classify the latched operands, flush denormals and order them by magnitude.
  always_comb begin
    b_sign_eff = b_q[31] ^ sub_q;
    a_zero     = (a_q[30:23] == 8'h00);
    b_zero     = (b_q[30:23] == 8'h00);
    a_inf      = (a_q[30:23] == 8'hff) && (a_q[22:0] == 23'h0);
    b_inf      = (b_q[30:23] == 8'hff) && (b_q[22:0] == 23'h0);
    a_nan      = (a_q[30:23] == 8'hff) && (a_q[22:0] != 23'h0);
    b_nan      = (b_q[30:23] == 8'hff) && (b_q[22:0] != 23'h0);
    mag_a      = a_zero ? 31'h0 : a_q[30:0];
    mag_b      = b_zero ? 31'h0 : b_q[30:0];
    a_ge_b     = (mag_a >= mag_b);
    mag_big    = a_ge_b ? mag_a : mag_b;
    mag_small  = a_ge_b ? mag_b : mag_a;
    exp_diff   = mag_big[30:23] - mag_small[30:23];
    shamt_u    = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
    spec_hit   = 1'b1;
    spec_val   = CANON_NAN;
    spec_flg   = 4'b0000;
    if (a_nan || b_nan) begin
      spec_val = CANON_NAN;
    end else if (a_inf && b_inf) begin
      if (a_q[31] == b_sign_eff) spec_val = {a_q[31], 8'hff, 23'h0};
      else                       spec_flg = 4'b1000;
    end else if (a_inf) begin
      spec_val = {a_q[31], 8'hff, 23'h0};
    end else if (b_inf) begin
      spec_val = {b_sign_eff, 8'hff, 23'h0};
    end else if (a_zero && b_zero) begin
      spec_val = {a_q[31] & b_sign_eff, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [53:0] align_ext;
  logic [26:0] small_aligned;

  // Shift the smaller significand right into {sig, guard, round, sticky}.
  always_comb begin
    align_ext     = {sig_small_q, 30'h0} >> shamt_q;
    small_aligned = {align_ext[53:28], align_ext[27] | (|align_ext[26:0])};
  end

  logic [27:0]       sum_raw;
  logic [26:0]       sum_norm;
  logic [4:0]        lzc;
  logic signed [9:0] exp_norm, exp_rnd;
  logic              grs_nz, round_up;
  logic [24:0]       sig_rnd;
  logic [22:0]       frac_rnd;
  logic [31:0]       calc_res;
  logic [3:0]        calc_flg;

  // Add/subtract, normalise, round to nearest even and apply range limits.
  always_comb begin
    if (eff_sub_q) sum_raw = {1'b0, sig_big_q, 3'b000} - {1'b0, al_small_q};
    else           sum_raw = {1'b0, sig_big_q, 3'b000} + {1'b0, al_small_q};
    lzc = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum_raw[i]) lzc = 5'(26 - i);
    end
    if (sum_raw[27]) begin
      sum_norm = {sum_raw[27:2], sum_raw[1] | sum_raw[0]};
      exp_norm = $signed({2'b00, exp_big_q}) + 10'sd1;
    end else begin
      sum_norm = sum_raw[26:0] << lzc;
      exp_norm = $signed({2'b00, exp_big_q}) - $signed({5'b00000, lzc});
    end
    grs_nz   = |sum_norm[2:0];
    round_up = sum_norm[2] & (sum_norm[1] | sum_norm[0] | sum_norm[3]);
    sig_rnd  = {1'b0, sum_norm[26:3]} + {24'h0, round_up};
    if (sig_rnd[24]) begin
      frac_rnd = sig_rnd[23:1];
      exp_rnd  = exp_norm + 10'sd1;
    end else begin
      frac_rnd = sig_rnd[22:0];
      exp_rnd  = exp_norm;
    end
    calc_res = {sign_q, exp_rnd[7:0], frac_rnd};
    calc_flg = {3'b000, grs_nz};
    if (sum_raw == 28'h0) begin
      calc_res = 32'h0;
      calc_flg = 4'b0000;
    end else if (exp_norm <= 10'sd0) begin
      calc_res = {sign_q, 31'h0};
      calc_flg = 4'b0011;
    end else if (exp_rnd >= 10'sd255) begin
      calc_res = {sign_q, 8'hff, 23'h0};
      calc_flg = 4'b0101;
    end
  end

  // Next-state and next-register values for the operation sequence.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    flags_d      = flags_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    special_d    = special_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    sign_d       = sign_q;
    eff_sub_d    = eff_sub_q;
    exp_big_d    = exp_big_q;
    sig_big_d    = sig_big_q;
    sig_small_d  = sig_small_q;
    shamt_d      = shamt_q;
    al_small_d   = al_small_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        special_d    = spec_hit;
        spec_res_d   = spec_val;
        spec_flags_d = spec_flg;
        sign_d       = a_ge_b ? a_q[31] : b_sign_eff;
        eff_sub_d    = a_q[31] ^ b_sign_eff;
        exp_big_d    = mag_big[30:23];
        sig_big_d    = {mag_big[30:23] != 8'h00, mag_big[22:0]};
        sig_small_d  = {mag_small[30:23] != 8'h00, mag_small[22:0]};
        shamt_d      = shamt_u;
        state_d      = ALIGN;
      end
      ALIGN: begin
        al_small_d = small_aligned;
        state_d    = ADDNORM;
      end
      ADDNORM: begin
        result_d = special_q ? spec_res_q : calc_res;
        flags_d  = special_q ? spec_flags_q : calc_flg;
        done_d   = 1'b1;
        state_d  = ROUND;
      end
      ROUND: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, operand/datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 32'h0;
      flags_q      <= 4'h0;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      sub_q        <= 1'b0;
      special_q    <= 1'b0;
      spec_res_q   <= 32'h0;
      spec_flags_q <= 4'h0;
      sign_q       <= 1'b0;
      eff_sub_q    <= 1'b0;
      exp_big_q    <= 8'h0;
      sig_big_q    <= 24'h0;
      sig_small_q  <= 24'h0;
      shamt_q      <= 5'h0;
      al_small_q   <= 27'h0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      special_q    <= special_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      sign_q       <= sign_d;
      eff_sub_q    <= eff_sub_d;
      exp_big_q    <= exp_big_d;
      sig_big_q    <= sig_big_d;
      sig_small_q  <= sig_small_d;
      shamt_q      <= shamt_d;
      al_small_q   <= al_small_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Testbench for fpu_addsub_seq: directed operations whose expected results are
// queued at issue time and retired against every done pulse.
module tb_fpu_addsub_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [3:0]  flags;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flg;
   } expect_t;

   expect_t expQ[$];
   int assertCount = 0;
   int failCount = 0;
   int doneCount = 0;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   fpu_addsub_seq #(
      .LATENCY(4),
      .CANON_NAN(32'h7fc00000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .sub(sub),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .result(result),
      .flags(flags)
   );

   // One comparison: counts it, and on a difference counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one start pulse at a falling edge and queue what the operation must produce.
   task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB, input logic opSub,
                                input logic [31:0] expRes, input logic [3:0] expFlg);
      expect_t entry;
      @(negedge clk);
      a = opA;
      b = opB;
      sub = opSub;
      start = 1'b1;
      entry.res = expRes;
      entry.flg = expFlg;
      expQ.push_back(entry);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called in the first cycle after accept; done must arrive in cycle 4.
   task automatic awaitDone(input string tag);
      int cycles;
      cycles = 1;
      while (!done && cycles < 12) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, "Latency"}, 36'(cycles), 36'd4);
      @(negedge clk);
   endtask

   task automatic runOp(input string tag, input logic [31:0] opA, input logic [31:0] opB, input logic opSub,
                        input logic [31:0] expRes, input logic [3:0] expFlg);
      applyStimulus(opA, opB, opSub, expRes, expFlg);
      awaitDone(tag);
   endtask

   // Every done pulse retires the oldest expectation and compares result and flags.
   always @(negedge clk) begin
      expect_t entry;
      if (!reset && done) begin
         doneCount++;
         checkOutput($sformatf("doneExpected#%0d", doneCount), 36'(expQ.size() > 0), 36'd1);
         if (expQ.size() > 0) begin
            entry = expQ.pop_front();
            checkOutput($sformatf("result#%0d", doneCount), 36'(result), 36'(entry.res));
            checkOutput($sformatf("flags#%0d", doneCount), 36'(flags), 36'(entry.flg));
         end
      end
   end

   // Directed sequence of operations, stalls and resets.
   initial begin
      int doneBefore;
      int cycles;
      expect_t dropped;

      #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("resetBusy", 36'(busy), 36'd0);
      checkOutput("resetDone", 36'(done), 36'd0);
      checkOutput("resetResult", 36'(result), 36'd0);
      checkOutput("resetFlags", 36'(flags), 36'd0);
      reset = 1'b0;

      $display("[TB] busy/done profile of 1.5 + 1.2");
      @(negedge clk);
      a = 32'h3fc00000;
      b = 32'h3f99999a;
      sub = 1'b0;
      start = 1'b1;
      dropped.res = 32'h402ccccd;
      dropped.flg = 4'b0000;
      expQ.push_back(dropped);
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         checkOutput($sformatf("busyCycle%0d", k), 36'(busy), 36'(k <= 4));
         checkOutput($sformatf("doneCycle%0d", k), 36'(done), 36'(k == 4));
         @(posedge clk);
         #1;
      end

      $display("[TB] arithmetic and special cases");
      runOp("oneMinusTwo",   32'h3f800000, 32'h40000000, 1'b1, 32'hbf800000, 4'b0000);
      runOp("exactCancel",   32'h3fc00000, 32'h3fc00000, 1'b1, 32'h00000000, 4'b0000);
      runOp("tieEven",       32'h3f800000, 32'h33800000, 1'b0, 32'h3f800000, 4'b0001);
      runOp("tieOdd",        32'h3f800001, 32'h33800000, 1'b0, 32'h3f800002, 4'b0001);
      runOp("overflow",      32'h7f7fffff, 32'h7f7fffff, 1'b0, 32'h7f800000, 4'b0101);
      runOp("infMinusInf",   32'h7f800000, 32'h7f800000, 1'b1, 32'h7fc00000, 4'b1000);
      runOp("nanInput",      32'h7f800001, 32'h3f800000, 1'b0, 32'h7fc00000, 4'b0000);
      runOp("negInfPlusOne", 32'hff800000, 32'h3f800000, 1'b0, 32'hff800000, 4'b0000);
      runOp("negZeroSum",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
      runOp("zeroMinusZero", 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000);
      runOp("underflow",     32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
      runOp("denormFlush",   32'h00000001, 32'h3f800000, 1'b0, 32'h3f800000, 4'b0000);
      runOp("threeMinusOne", 32'h40400000, 32'hbf800000, 1'b0, 32'h40000000, 4'b0000);

      $display("[TB] start held high through busy");
      doneBefore = doneCount;
      @(negedge clk);
      a = 32'h3fc00000;
      b = 32'h3f99999a;
      sub = 1'b0;
      start = 1'b1;
      dropped.res = 32'h402ccccd;
      dropped.flg = 4'b0000;
      expQ.push_back(dropped);
      @(negedge clk);
      a = 32'h40400000;
      b = 32'hbf800000;
      cycles = 1;
      while (!done && cycles < 12) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("heldStartLatency", 36'(cycles), 36'd4);
      start = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("heldStartDoneCount", 36'(doneCount - doneBefore), 36'd1);
      checkOutput("heldStartIdle", 36'(busy), 36'd0);
      checkOutput("heldStartResultHeld", 36'(result), 36'h402ccccd);
      runOp("secondAfterIdle", 32'h40400000, 32'hbf800000, 1'b0, 32'h40000000, 4'b0000);

      $display("[TB] reset during ALIGN");
      applyStimulus(32'h3f800000, 32'h40000000, 1'b1, 32'hbf800000, 4'b0000);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abortBusy", 36'(busy), 36'd0);
      checkOutput("abortResult", 36'(result), 36'd0);
      checkOutput("abortFlags", 36'(flags), 36'd0);
      dropped = expQ.pop_back();
      doneBefore = doneCount;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("abortNoDone", 36'(doneCount - doneBefore), 36'd0);
      checkOutput("abortResultKept", 36'(result), 36'd0);
      checkOutput("abortIdle", 36'(busy), 36'd0);
      runOp("afterReset", 32'h3fc00000, 32'h3f99999a, 1'b0, 32'h402ccccd, 4'b0000);

      repeat (4) @(negedge clk);
      checkOutput("queueDrained", 36'(expQ.size()), 36'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
